// File: rtl/cascade_countdown_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cascade_countdown_timer_pkg                                |
// | Description : Shared state encoding and count-direction constants for    |
// |               the cascaded digit timer and its digit sub-module.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cascade_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cascade_countdown_timer_digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : timer_digit                                                |
// | Description : One up/down digit of the cascade. Wraps between 0 and      |
// |               MAX_VALUE, clamps out-of-range set values to MAX_VALUE.    |
// | Ports       : clk        - clock                                         |
// |               set        - load set_value (highest priority)             |
// |               set_value  - value to load                                 |
// |               carry_in   - step this digit                               |
// |               dir        - 0 = down, 1 = up                              |
// |               value      - registered digit value                        |
// |               value_next - value the digit takes on the next edge        |
// |               carry_out  - carry_in while sitting on the wrap boundary   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module timer_digit
  import cascade_countdown_timer_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE = '1
) (
  input  logic             clk,
  input  logic             set,
  input  logic [WIDTH-1:0] set_value,
  input  logic             carry_in,
  input  logic             dir,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             carry_out
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // The top drives set during reset, so this flop needs no reset of its own.
  always_comb begin
    value_d = value_q;
    if (set) begin
      value_d = (set_value > MAX_VALUE) ? MAX_VALUE : set_value;
    end else if (carry_in) begin
      if (dir == DIR_UP) begin
        value_d = (value_q == MAX_VALUE) ? '0 : value_q + 1'b1;
      end else begin
        value_d = (value_q == '0) ? MAX_VALUE : value_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign carry_out  = carry_in && ((dir == DIR_UP) ? (value_q == MAX_VALUE) : (value_q == '0));
  assign value      = value_q;
  assign value_next = value_d;

endmodule
`default_nettype wire

// File: rtl/cascade_countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cascade_countdown_timer                                    |
// | Description : Multi-digit up/down timer with prescaler, load, start,     |
// |               pause, terminal detect, stop/wrap mode and done strobe.    |
// | Ports       : clk, rst (sync, active-high)                               |
// |               load/load_value - load value, return to IDLE               |
// |               start / pause   - begin/resume and suspend counting        |
// |               dir             - 0 = down, 1 = up                         |
// |               wrap_mode       - 0 = stop at terminal, 1 = keep running   |
// |               value           - packed count                             |
// |               running/tick/done - status and strobes                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cascade_countdown_timer
  import cascade_countdown_timer_pkg::*;
#(
  parameter int                         DIGITS    = 4,
  parameter int                         DIGIT_W   = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]  DIGIT_MAX = 16'h5959,
  parameter logic [DIGITS*DIGIT_W-1:0]  SET_VALUE = 16'h0100,
  parameter int                         PRESCALE  = 100000000,
  parameter int                         PRE_W     = 27
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [DIGITS*DIGIT_W-1:0]   load_value,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        dir,
  input  logic                        wrap_mode,
  output logic [DIGITS*DIGIT_W-1:0]   value,
  output logic                        running,
  output logic                        tick,
  output logic                        done
);

  localparam int               VW       = DIGITS * DIGIT_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [VW-1:0]    reload_q, reload_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             running_q, running_d;

  logic             step_en;
  logic             digit_set;
  logic [VW-1:0]    digit_set_value;
  logic [VW-1:0]    digit_next;
  logic [DIGITS:0]  carry;
  logic             terminal_next;

  assign carry[0] = step_en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    timer_digit #(
      .WIDTH     (DIGIT_W),
      .MAX_VALUE (DIGIT_MAX[i*DIGIT_W +: DIGIT_W])
    ) u_digit (
      .clk        (clk),
      .set        (digit_set),
      .set_value  (digit_set_value[i*DIGIT_W +: DIGIT_W]),
      .carry_in   (carry[i]),
      .dir        (dir),
      .value      (value[i*DIGIT_W +: DIGIT_W]),
      .value_next (digit_next[i*DIGIT_W +: DIGIT_W]),
      .carry_out  (carry[i+1])
    );
  end

  // Terminal is judged on the post-step value so done lines up with it.
  assign terminal_next = (dir == DIR_UP) ? (digit_next == DIGIT_MAX) : (digit_next == '0);

  always_comb begin
    state_d         = state_q;
    pre_d           = pre_q;
    reload_d        = reload_q;
    tick_d          = 1'b0;
    done_d          = 1'b0;
    step_en         = 1'b0;
    digit_set       = 1'b0;
    digit_set_value = load_value;

    if (rst) begin
      digit_set       = 1'b1;
      digit_set_value = SET_VALUE;
    end else if (load) begin
      digit_set = 1'b1;
      reload_d  = load_value;
      pre_d     = '0;
      state_d   = ST_IDLE;
    end else if (start && (state_q != ST_RUN)) begin
      if (state_q == ST_DONE) begin
        digit_set       = 1'b1;
        digit_set_value = reload_q;
      end
      pre_d   = '0;
      state_d = ST_RUN;
    end else if (pause && !start && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (state_q == ST_RUN) begin
      // A start while already running is ignored, so counting carries on.
      if (tick_q) begin
        step_en = 1'b1;
        if (terminal_next) begin
          done_d = 1'b1;
          if (!wrap_mode) begin
            state_d = ST_DONE;
          end
        end
      end
      if (state_d == ST_RUN) begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      reload_q  <= SET_VALUE;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      reload_q  <= reload_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cascade_countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cascade_countdown_timer                                 |
// | Description : Self-checking bench for cascade_countdown_timer. The       |
// |               reference model treats the count as one mixed-radix        |
// |               integer and steps it with modular arithmetic.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cascade_countdown_timer;

  localparam int          PRESCALE = 4;
  localparam int          NTOT     = 3600;  // 6*10*6*10 states of mm:ss
  localparam logic [15:0] MAXV     = 16'h5959;
  localparam logic [15:0] RSTV     = 16'h0100;
  localparam int          M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic        dir = 1'b0, wrap_mode = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] value;
  logic        running, tick, done;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_n, m_mode, m_cnt;
  logic [15:0] m_reload;
  logic        m_tick, m_done;

  cascade_countdown_timer #(
    .DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(16'h5959), .SET_VALUE(16'h0100),
    .PRESCALE(PRESCALE), .PRE_W(3)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .dir(dir), .wrap_mode(wrap_mode),
    .value(value), .running(running), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] clamp(input logic [15:0] v);
    logic [15:0] r;
    logic [15:0] m;
    m = MAXV;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = (v[i*4 +: 4] > m[i*4 +: 4]) ? m[i*4 +: 4] : v[i*4 +: 4];
    return r;
  endfunction

  function automatic int to_int(input logic [15:0] v);
    logic [15:0] m;
    int n, w;
    m = MAXV; n = 0; w = 1;
    for (int i = 0; i < 4; i++) begin
      n += int'(v[i*4 +: 4]) * w;
      w *= int'(m[i*4 +: 4]) + 1;
    end
    return n;
  endfunction

  function automatic logic [15:0] from_int(input int n);
    logic [15:0] m;
    logic [15:0] r;
    int k, radix;
    m = MAXV; k = n; r = '0;
    for (int i = 0; i < 4; i++) begin
      radix = int'(m[i*4 +: 4]) + 1;
      r[i*4 +: 4] = 4'(k % radix);
      k = k / radix;
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic nt, nd;
    nt = 1'b0; nd = 1'b0;
    if (rst) begin
      m_n = to_int(RSTV); m_reload = RSTV; m_mode = M_IDLE; m_cnt = 0;
    end else if (load) begin
      m_n = to_int(clamp(load_value)); m_reload = load_value; m_mode = M_IDLE; m_cnt = 0;
    end else if (start && m_mode != M_RUN) begin
      if (m_mode == M_DONE) m_n = to_int(clamp(m_reload));
      m_mode = M_RUN; m_cnt = 0;
    end else if (pause && !start && m_mode == M_RUN) begin
      m_mode = M_PAUSED;
    end else if (m_mode == M_RUN) begin
      if (m_tick) begin
        m_n = dir ? (m_n + 1) % NTOT : (m_n + NTOT - 1) % NTOT;
        if (m_n == (dir ? NTOT - 1 : 0)) begin
          nd = 1'b1;
          if (!wrap_mode) m_mode = M_DONE;
        end
      end
      if (m_mode == M_RUN) begin
        m_cnt++;
        if (m_cnt == PRESCALE) begin
          m_cnt = 0; nt = 1'b1;
        end
      end
    end
    m_tick = nt; m_done = nd;
  endtask

  task automatic step_cycle(input logic r, input logic ld, input logic [15:0] lv,
                            input logic st, input logic pa);
    rst = r; load = ld; load_value = lv; start = st; pause = pa;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    dir = 1'b0; wrap_mode = 1'b0;
    step_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    total++; if (value !== 16'h0100) begin bad++; $display("FAIL reset_value got=%h exp=0100", value); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
    total++; if ({tick, done} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {tick, done}); end
  endtask

  task automatic test_basic_count();
    int ticks;
    step_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running got=%b exp=1", running); end
    idle_cycles(4);
    total++; if (tick !== 1'b1 || value !== 16'h0100) begin bad++; $display("FAIL first_tick got tick=%b value=%h exp tick=1 value=0100", tick, value); end
    idle_cycles(1);
    total++; if (value !== 16'h0059) begin bad++; $display("FAIL step1 got=%h exp=0059", value); end
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      step_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      if (tick === 1'b1) ticks++;
    end
    total++; if (ticks != 1) begin bad++; $display("FAIL tick_period got=%0d exp=1", ticks); end
    total++; if (value !== 16'h0058) begin bad++; $display("FAIL step2 got=%h exp=0058", value); end
  endtask

  task automatic test_stop_at_zero();
    int changes;
    dir = 1'b0; wrap_mode = 1'b0;
    step_cycle(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle_cycles(5);
    total++; if (value !== 16'h0001 || done !== 1'b0) begin bad++; $display("FAIL down_0001 got value=%h done=%b exp 0001/0", value, done); end
    idle_cycles(4);
    total++; if (value !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL reach_zero got value=%h done=%b running=%b exp 0000/1/0", value, done, running); end
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      if (value !== 16'h0000 || done !== 1'b0 || tick !== 1'b0) changes++;
    end
    total++; if (changes != 0) begin bad++; $display("FAIL done_frozen got=%0d exp=0 bad cycles", changes); end
  endtask

  task automatic test_restart_and_load();
    step_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    total++; if (value !== 16'h0002 || running !== 1'b1) begin bad++; $display("FAIL restart got value=%h running=%b exp 0002/1", value, running); end
    idle_cycles(5);
    total++; if (value !== 16'h0001) begin bad++; $display("FAIL restart_count got=%h exp=0001", value); end
    step_cycle(1'b0, 1'b1, 16'h0123, 1'b0, 1'b0);
    total++; if (value !== 16'h0123 || running !== 1'b0) begin bad++; $display("FAIL load_in_run got value=%h running=%b exp 0123/0", value, running); end
  endtask

  task automatic test_up_wrap();
    dir = 1'b1; wrap_mode = 1'b1;
    step_cycle(1'b0, 1'b1, 16'h5958, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle_cycles(5);
    total++; if (value !== 16'h5959 || done !== 1'b1 || running !== 1'b1) begin bad++; $display("FAIL up_terminal got value=%h done=%b running=%b exp 5959/1/1", value, done, running); end
    idle_cycles(4);
    total++; if (value !== 16'h0000 || done !== 1'b0 || running !== 1'b1) begin bad++; $display("FAIL up_wrap got value=%h done=%b running=%b exp 0000/0/1", value, done, running); end
  endtask

  task automatic test_pause();
    int moved;
    dir = 1'b0; wrap_mode = 1'b0;
    step_cycle(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle_cycles(2);
    step_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      if (value !== 16'h0100 || tick !== 1'b0 || running !== 1'b0) moved++;
    end
    total++; if (moved != 0) begin bad++; $display("FAIL pause_hold got=%0d exp=0 bad cycles", moved); end
    step_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle_cycles(3);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL resume_early_tick got=%b exp=0", tick); end
    idle_cycles(1);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL resume_tick got=%b exp=1", tick); end
    idle_cycles(1);
    total++; if (value !== 16'h0059) begin bad++; $display("FAIL resume_step got=%h exp=0059", value); end
  endtask

  task automatic test_clamp_and_reset();
    step_cycle(1'b0, 1'b1, 16'h7A99, 1'b0, 1'b0);
    total++; if (value !== 16'h5959) begin bad++; $display("FAIL clamp got=%h exp=5959", value); end
    step_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_beats_pause got=%b exp=1", running); end
    idle_cycles(4);
    step_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    total++; if (value !== 16'h0100 || running !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_run got value=%h run=%b tick=%b done=%b exp 0100/0/0/0", value, running, tick, done); end
    idle_cycles(6);
    total++; if (value !== 16'h0100 || running !== 1'b0) begin bad++; $display("FAIL rst_idle got value=%h running=%b exp 0100/0", value, running); end
  endtask

  task automatic test_random();
    int r, shown;
    logic rs, ld, st, pa;
    logic [15:0] lv, ev;
    shown = 0;
    for (int c = 0; c < 3000; c++) begin
      rs = 1'b0; ld = 1'b0; st = 1'b0; pa = 1'b0; lv = '0;
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 79) == 0) wrap_mode = ~wrap_mode;
      r = $urandom_range(0, 99);
      if (r == 0) rs = 1'b1;
      else if (r < 4) begin
        ld = 1'b1;
        case ($urandom_range(0, 2))
          0: lv = 16'($urandom);
          1: lv = 16'($urandom_range(0, 3));
          default: lv = 16'h5950 | 16'($urandom_range(0, 9));
        endcase
      end
      else if (r < 8) st = 1'b1;
      else if (r < 10) pa = 1'b1;
      else if (r == 10) begin st = 1'b1; pa = 1'b1; end
      step_cycle(rs, ld, lv, st, pa);
      ev = from_int(m_n);
      total++;
      if (value !== ev || running !== (m_mode == M_RUN) || tick !== m_tick || done !== m_done) begin
        bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random_cycle%0d got value=%h run=%b tick=%b done=%b exp value=%h run=%b tick=%b done=%b",
                   c, value, running, tick, done, ev, (m_mode == M_RUN), m_tick, m_done);
        end
      end
    end
  endtask

  initial begin
    m_n = 0; m_mode = M_IDLE; m_cnt = 0; m_reload = RSTV; m_tick = 1'b0; m_done = 1'b0;
    test_reset();
    test_basic_count();
    test_stop_at_zero();
    test_restart_and_load();
    test_up_wrap();
    test_pause();
    test_clamp_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
